alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 68 ++++++
 tb/tb_alu_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one pipelined ALU between two requesters.
// An in-flight tracker tags each result with its requester id as it leaves the ALU.
module alu_arbiter #(
    parameter int ALU_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hold,
    input  logic       req0_valid,
    input  logic       req1_valid,
    output logic       req0_ready,
    output logic       req1_ready,
    input  logic [3:0] req0_op,
    input  logic [3:0] req1_op,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic [3:0] alu_instruction,
    output logic [7:0] alu_inputA,
    output logic [7:0] alu_inputB,
    input  logic [7:0] alu_result,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [7:0] rsp_data,
    output logic       busy
);
    logic               r_last;
    logic [ALU_LAT-1:0] r_vld;
    logic [ALU_LAT-1:0] r_id;
    logic               w_en;
    logic               w_g0;
    logic               w_g1;
    logic               w_xfer;

    // Requester 1 wins when alone or when requester 0 had the last grant.
    always_comb begin
        w_en   = reset & ~hold;
        w_g1   = w_en & req1_valid & (~req0_valid | ~r_last);
        w_g0   = w_en & req0_valid & ~w_g1;
        w_xfer = w_g0 | w_g1;
    end

    assign req0_ready      = w_g0;
    assign req1_ready      = w_g1;
    assign alu_instruction = w_g0 ? req0_op : w_g1 ? req1_op : 4'h0;
    assign alu_inputA      = w_g0 ? req0_a  : w_g1 ? req1_a  : 8'h00;
    assign alu_inputB      = w_g0 ? req0_b  : w_g1 ? req1_b  : 8'h00;
    assign busy            = (|r_vld) | rsp_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_vld     <= '0;
            r_id      <= '0;
            r_last    <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= 8'h00;
        end else begin
            r_vld     <= (r_vld << 1) | ALU_LAT'(w_xfer);
            r_id      <= (r_id << 1) | ALU_LAT'(w_g1);
            r_last    <= w_xfer ? w_g1 : r_last;
            rsp_valid <= r_vld[ALU_LAT-1];
            rsp_id    <= r_vld[ALU_LAT-1] ? r_id[ALU_LAT-1] : rsp_id;
            rsp_data  <= r_vld[ALU_LAT-1] ? alu_result : rsp_data;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vector table, multi-cycle corner sequences and random traffic
// checked every cycle against a queue-based model of grants and tagged responses.
module tb_alu_arbiter;
    localparam int L = 2;

    logic       clk = 1'b0;
    logic       reset, hold, req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0] req0_op, req1_op, alu_instruction;
    logic [7:0] req0_a, req0_b, req1_a, req1_b, alu_inputA, alu_inputB, alu_result, rsp_data;
    logic       rsp_valid, rsp_id, busy;

    always #5 clk = ~clk;

    alu_arbiter #(.ALU_LAT(L)) dut (
        .clk(clk), .reset(reset), .hold(hold),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_op(req0_op), .req1_op(req1_op),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .alu_instruction(alu_instruction), .alu_inputA(alu_inputA), .alu_inputB(alu_inputB),
        .alu_result(alu_result), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy)
    );

    function automatic logic [7:0] alu_f(logic [3:0] op, logic [7:0] a, logic [7:0] b);
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return a & b;
            4'h3:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    // Pipelined ALU: result for an issue in cycle N is on alu_result in cycle N+L.
    logic [7:0] alu_pipe [L];
    always_ff @(posedge clk) begin
        alu_pipe[0] <= alu_f(alu_instruction, alu_inputA, alu_inputB);
        for (int i = 1; i < L; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign alu_result = alu_pipe[L-1];

    typedef struct {
        int         issue;
        logic       id;
        logic [7:0] data;
    } pend_t;

    typedef struct {
        logic       h, v0, v1;
        logic [3:0] o0;
        logic [7:0] a0, b0;
        logic [3:0] o1;
        logic [7:0] a1, b1;
        logic       r0, r1;
        logic [3:0] ei;
        logic [7:0] ea, eb;
    } vec_t;

    pend_t      q[$];
    logic [7:0] got[$];
    int         cyc = 0, checks = 0, errors = 0;
    logic       m_last = 1'b1;
    logic       s_r0, s_r1;
    vec_t       tbl[10];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic set_in(logic h, logic v0, logic v1, logic [3:0] o0, logic [7:0] a0, logic [7:0] b0,
                          logic [3:0] o1, logic [7:0] a1, logic [7:0] b1);
        hold = h; req0_valid = v0; req1_valid = v1;
        req0_op = o0; req0_a = a0; req0_b = b0;
        req1_op = o1; req1_a = a1; req1_b = b1;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 4'h0, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00);
    endtask

    // One clock cycle: check outputs at the falling edge, advance the model, cross the rising edge.
    task automatic step();
        bit         g0, g1, rv, bz;
        logic [7:0] ed;
        @(negedge clk);
        g0 = 0; g1 = 0;
        if (reset && !hold) begin
            if (req0_valid && req1_valid) begin
                g0 = m_last;
                g1 = !m_last;
            end else begin
                g0 = req0_valid;
                g1 = req1_valid;
            end
        end
        chk("req0_ready", req0_ready, g0);
        chk("req1_ready", req1_ready, g1);
        chk("alu_instruction", alu_instruction, g0 ? req0_op : g1 ? req1_op : 4'h0);
        chk("alu_inputA", alu_inputA, g0 ? req0_a : g1 ? req1_a : 8'h00);
        chk("alu_inputB", alu_inputB, g0 ? req0_b : g1 ? req1_b : 8'h00);
        bz = q.size() > 0;
        rv = bz && (q[0].issue + L + 1 == cyc);
        chk("busy", busy, bz);
        chk("rsp_valid", rsp_valid, rv);
        if (rv) begin
            chk("rsp_id", rsp_id, q[0].id);
            chk("rsp_data", rsp_data, q[0].data);
            void'(q.pop_front());
        end
        if (rsp_valid === 1'b1) got.push_back(rsp_data);
        s_r0 = req0_ready;
        s_r1 = req1_ready;
        if (g0 || g1) begin
            ed = g0 ? alu_f(req0_op, req0_a, req0_b) : alu_f(req1_op, req1_a, req1_b);
            q.push_back('{cyc, g1, ed});
            m_last = g1;
        end
        if (!reset) begin
            q.delete();
            m_last = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(int n);
        idle();
        repeat (n) step();
    endtask

    initial begin
        reset = 1'b0;
        set_in(0, 1, 1, 4'h3, 8'h11, 8'h22, 4'h4, 8'h33, 8'h44);
        @(posedge clk);
        #1;
        step();
        step();
        chk("reset_rsp_data", rsp_data, 8'h00);
        chk("reset_rsp_id", rsp_id, 1'b0);
        reset = 1'b1;

        tbl[0] = '{0, 1, 1, 4'h0, 8'h01, 8'h01, 4'h1, 8'h05, 8'h07, 1, 0, 4'h0, 8'h01, 8'h01};
        tbl[1] = '{0, 1, 1, 4'h0, 8'h01, 8'h01, 4'h1, 8'h05, 8'h07, 0, 1, 4'h1, 8'h05, 8'h07};
        tbl[2] = '{0, 1, 1, 4'h0, 8'h01, 8'h01, 4'h1, 8'h05, 8'h07, 1, 0, 4'h0, 8'h01, 8'h01};
        tbl[3] = '{0, 1, 1, 4'h0, 8'h01, 8'h01, 4'h1, 8'h05, 8'h07, 0, 1, 4'h1, 8'h05, 8'h07};
        tbl[4] = '{0, 1, 0, 4'h0, 8'h12, 8'h34, 4'h0, 8'h00, 8'h00, 1, 0, 4'h0, 8'h12, 8'h34};
        tbl[5] = '{0, 0, 0, 4'h2, 8'h55, 8'h66, 4'h3, 8'h77, 8'h88, 0, 0, 4'h0, 8'h00, 8'h00};
        tbl[6] = '{0, 0, 1, 4'h0, 8'h00, 8'h00, 4'h0, 8'hFF, 8'h01, 0, 1, 4'h0, 8'hFF, 8'h01};
        tbl[7] = '{0, 1, 0, 4'h1, 8'h00, 8'h01, 4'h0, 8'h00, 8'h00, 1, 0, 4'h1, 8'h00, 8'h01};
        tbl[8] = '{1, 1, 1, 4'h0, 8'h01, 8'h01, 4'h1, 8'h05, 8'h07, 0, 0, 4'h0, 8'h00, 8'h00};
        tbl[9] = '{0, 0, 1, 4'h0, 8'h00, 8'h00, 4'hF, 8'h3C, 8'h0F, 0, 1, 4'hF, 8'h3C, 8'h0F};
        got.delete();
        for (int i = 0; i < 10; i++) begin
            set_in(tbl[i].h, tbl[i].v0, tbl[i].v1, tbl[i].o0, tbl[i].a0, tbl[i].b0,
                   tbl[i].o1, tbl[i].a1, tbl[i].b1);
            #2;
            chk("tbl_req0_ready", req0_ready, tbl[i].r0);
            chk("tbl_req1_ready", req1_ready, tbl[i].r1);
            chk("tbl_instr", alu_instruction, tbl[i].ei);
            chk("tbl_inputA", alu_inputA, tbl[i].ea);
            chk("tbl_inputB", alu_inputB, tbl[i].eb);
            step();
        end
        drain(5);
        begin
            logic [7:0] exp_rsp [8];
            exp_rsp = '{8'h02, 8'hFE, 8'h02, 8'hFE, 8'h46, 8'h00, 8'hFF, 8'h33};
            chk("tbl_rsp_count", got.size(), 8);
            for (int i = 0; i < 8 && i < got.size(); i++) chk("tbl_rsp_data", got[i], exp_rsp[i]);
        end

        got.delete();
        for (int i = 0; i < 8; i++) begin
            set_in(0, 0, 1, 4'h0, 8'h00, 8'h00, 4'h0, 8'(i), 8'h01);
            step();
        end
        drain(6);
        chk("b2b_rsp_count", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++) chk("b2b_rsp_data", got[i], 8'(i + 1));

        set_in(0, 0, 1, 4'h2, 8'hF0, 8'h3C, 4'h2, 8'hF0, 8'h3C);
        step();
        drain(4);
        got.delete();
        set_in(1, 1, 1, 4'h0, 8'h01, 8'h01, 4'h1, 8'h05, 8'h07);
        repeat (5) step();
        chk("hold_no_rsp", got.size(), 0);
        hold = 1'b0;
        step();
        chk("hold_release_r0", s_r0, 1'b1);
        chk("hold_release_r1", s_r1, 1'b0);
        drain(5);

        set_in(0, 1, 0, 4'h0, 8'h10, 8'h20, 4'h0, 8'h00, 8'h00);
        step();
        set_in(0, 0, 1, 4'h0, 8'h00, 8'h00, 4'h1, 8'h30, 8'h01);
        step();
        got.delete();
        idle();
        reset = 1'b0;
        step();
        reset = 1'b1;
        drain(5);
        chk("rst_no_rsp", got.size(), 0);
        chk("rst_busy", busy, 1'b0);
        set_in(0, 1, 1, 4'h0, 8'h01, 8'h02, 4'h0, 8'h03, 8'h04);
        step();
        chk("rst_contention_r0", s_r0, 1'b1);
        drain(5);

        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) != 0);
            set_in($urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                   4'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), 8'($urandom), 8'($urandom));
            step();
        end
        reset = 1'b1;
        drain(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
